draw_menu_sel: RTL and testbench

Parametrised successor of the fixed single-button menu renderer. Draws the screen border, background and N_BTN vertically stacked buttons. Keyboard pulses move a selection highlight, which blinks at a frame-based rate. On confirm it issues a one-cycle choice handshake to the game-state controller. It sits between the VGA timing generator and the output mux, and delays timing sideband signals to stay pixel-aligned.

---
 rtl/menu_pkg.sv | 18 +
 rtl/menu_nav_fsm.sv | 134 +++++++++++++
 rtl/draw_menu_sel.sv | 126 ++++++++++++
 tb/tb_draw_menu_sel.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types and default constants for the menu renderer.
package menu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_NAV     = 2'd1,
      ST_CONFIRM = 2'd2,
      ST_DONE    = 2'd3
   } menu_state_e;

   localparam int          DEF_H_RES      = 1024;
   localparam int          DEF_V_RES      = 768;
   localparam logic [11:0] DEF_BORDER_RGB = 12'hF00;
   localparam logic [11:0] DEF_BG_RGB     = 12'h888;
   localparam logic [11:0] DEF_BTN_RGB    = 12'h186;
   localparam logic [11:0] DEF_SEL_RGB    = 12'hFF0;

endpackage

// File: rtl/menu_nav_fsm.sv
// Menu navigation: selection, frame-rate blink and confirm countdown.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | menu hidden, waiting for menu_enable
//   NAV     | keys move the selection, highlight blinks per frame
//   CONFIRM | highlight solid, counting frames before issuing choice
//   DONE    | choice issued and held, highlight off until disabled
module menu_nav_fsm
   import menu_pkg::*;
#(
   parameter int N_BTN          = 4,
   parameter int BLINK_FRAMES   = 16,
   parameter int CONFIRM_FRAMES = 30
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vblnk_in,
   input  logic                     menu_enable,
   input  logic                     key_up,
   input  logic                     key_down,
   input  logic                     key_enter,
   output logic [$clog2(N_BTN)-1:0] sel_idx,
   output logic [$clog2(N_BTN)-1:0] choice,
   output logic                     choice_valid,
   output logic                     highlight_on,
   output logic                     active
);

   localparam int SEL_W   = $clog2(N_BTN);
   localparam int CNT_MAX = (BLINK_FRAMES > CONFIRM_FRAMES) ? BLINK_FRAMES : CONFIRM_FRAMES;
   localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N_BTN - 1);
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [CNT_W-1:0] CONF_LAST  = CNT_W'(CONFIRM_FRAMES - 1);

   menu_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] choice_q, choice_d;
   logic             valid_q, valid_d;
   logic             vblnk_q;
   logic             tick;

   assign tick = vblnk_in & ~vblnk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         phase_q  <= 1'b1;
         sel_q    <= '0;
         choice_q <= '0;
         valid_q  <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         sel_q    <= sel_d;
         choice_q <= choice_d;
         valid_q  <= valid_d;
         vblnk_q  <= vblnk_in;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      sel_d    = sel_q;
      choice_d = choice_q;
      valid_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (menu_enable) begin
               state_d = ST_NAV;
               sel_d   = '0;
               cnt_d   = '0;
               phase_d = 1'b1;
            end
         end
         ST_NAV: begin
            if (!menu_enable) begin
               state_d = ST_IDLE;
            end else if (key_enter) begin
               state_d = ST_CONFIRM;
               cnt_d   = '0;
            end else begin
               // simultaneous up+down cancel out
               if (key_up && !key_down) begin
                  sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
               end else if (key_down && !key_up) begin
                  sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
               end
               if (tick) begin
                  if (cnt_q == BLINK_LAST) begin
                     cnt_d   = '0;
                     phase_d = ~phase_q;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         ST_CONFIRM: begin
            if (!menu_enable) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (cnt_q == CONF_LAST) begin
                  choice_d = sel_q;
                  valid_d  = 1'b1;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (!menu_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sel_idx      = sel_q;
   assign choice       = choice_q;
   assign choice_valid = valid_q;
   assign active       = (state_q != ST_IDLE);
   assign highlight_on = (state_q == ST_NAV) ? phase_q : (state_q == ST_CONFIRM);

endmodule

// File: rtl/draw_menu_sel.sv
// Menu renderer: border, background and N_BTN stacked buttons with a
// blinking selection highlight, pixel-aligned with the timing sideband.
module draw_menu_sel
   import menu_pkg::*;
#(
   parameter int          H_RES          = DEF_H_RES,
   parameter int          V_RES          = DEF_V_RES,
   parameter int          BORDER_W       = 3,
   parameter logic [11:0] BORDER_RGB     = DEF_BORDER_RGB,
   parameter logic [11:0] BG_RGB         = DEF_BG_RGB,
   parameter logic [11:0] BTN_RGB        = DEF_BTN_RGB,
   parameter logic [11:0] SEL_RGB        = DEF_SEL_RGB,
   parameter int          N_BTN          = 4,
   parameter int          BTN_X          = 500,
   parameter int          BTN_Y0         = 320,
   parameter int          BTN_W          = 61,
   parameter int          BTN_H          = 31,
   parameter int          BTN_GAP        = 20,
   parameter int          BLINK_FRAMES   = 16,
   parameter int          CONFIRM_FRAMES = 30
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [10:0]              hcount_in,
   input  logic [9:0]               vcount_in,
   input  logic                     hblnk_in,
   input  logic                     vblnk_in,
   input  logic                     menu_enable,
   input  logic                     key_up,
   input  logic                     key_down,
   input  logic                     key_enter,
   output logic [10:0]              hcount_out,
   output logic [9:0]               vcount_out,
   output logic                     hblnk_out,
   output logic                     vblnk_out,
   output logic [11:0]              rgb_out,
   output logic [$clog2(N_BTN)-1:0] sel_idx,
   output logic [$clog2(N_BTN)-1:0] choice,
   output logic                     choice_valid
);

   localparam int SEL_W = $clog2(N_BTN);

   logic             highlight_on;
   logic             active;
   logic [31:0]      h32, v32;
   logic             in_border;
   logic             in_btn;
   logic [SEL_W-1:0] hit_idx;
   logic [11:0]      rgb_d, rgb_q;
   logic [10:0]      hcount_q;
   logic [9:0]       vcount_q;
   logic             hblnk_q, vblnk_q;

   menu_nav_fsm #(
      .N_BTN          (N_BTN),
      .BLINK_FRAMES   (BLINK_FRAMES),
      .CONFIRM_FRAMES (CONFIRM_FRAMES)
   ) u_nav (
      .clk          (clk),
      .rst_n        (rst_n),
      .vblnk_in     (vblnk_in),
      .menu_enable  (menu_enable),
      .key_up       (key_up),
      .key_down     (key_down),
      .key_enter    (key_enter),
      .sel_idx      (sel_idx),
      .choice       (choice),
      .choice_valid (choice_valid),
      .highlight_on (highlight_on),
      .active       (active)
   );

   assign h32 = {21'd0, hcount_in};
   assign v32 = {22'd0, vcount_in};

   assign in_border = (v32 < BORDER_W) || (v32 > V_RES - 1 - BORDER_W) ||
                      (h32 < BORDER_W) || (h32 > H_RES - 1 - BORDER_W);

   always_comb begin
      in_btn  = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < N_BTN; i++) begin
         if ((h32 >= BTN_X) && (h32 <= BTN_X + BTN_W - 1) &&
             (v32 >= BTN_Y0 + i * (BTN_H + BTN_GAP)) &&
             (v32 <= BTN_Y0 + i * (BTN_H + BTN_GAP) + BTN_H - 1)) begin
            in_btn  = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      rgb_d = BG_RGB;
      if (hblnk_in || vblnk_in || !active) begin
         rgb_d = 12'h000;
      end else if (in_border) begin
         rgb_d = BORDER_RGB;
      end else if (in_btn) begin
         rgb_d = ((hit_idx == sel_idx) && highlight_on) ? SEL_RGB : BTN_RGB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q    <= '0;
         hcount_q <= '0;
         vcount_q <= '0;
         hblnk_q  <= 1'b0;
         vblnk_q  <= 1'b0;
      end else begin
         rgb_q    <= rgb_d;
         hcount_q <= hcount_in;
         vcount_q <= vcount_in;
         hblnk_q  <= hblnk_in;
         vblnk_q  <= vblnk_in;
      end
   end

   assign rgb_out    = rgb_q;
   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign hblnk_out  = hblnk_q;
   assign vblnk_out  = vblnk_q;

endmodule

// File: tb/tb_draw_menu_sel.sv
// Directed bench for draw_menu_sel: pixel colours, navigation, confirm and reset.
module tb_draw_menu_sel;

   localparam logic [11:0] C_BRD = 12'hF00;
   localparam logic [11:0] C_BG  = 12'h888;
   localparam logic [11:0] C_BTN = 12'h186;
   localparam logic [11:0] C_SEL = 12'hFF0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        hblnk_in, vblnk_in;
   logic        menu_enable, key_up, key_down, key_enter;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;
   logic        hblnk_out, vblnk_out;
   logic [11:0] rgb_out;
   logic [1:0]  sel_idx, choice;
   logic        choice_valid;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   logic [11:0] exp_rgb_q[$];
   logic [10:0] exp_h_q[$];
   logic [9:0]  exp_v_q[$];

   draw_menu_sel dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hcount_in    (hcount_in),
      .vcount_in    (vcount_in),
      .hblnk_in     (hblnk_in),
      .vblnk_in     (vblnk_in),
      .menu_enable  (menu_enable),
      .key_up       (key_up),
      .key_down     (key_down),
      .key_enter    (key_enter),
      .hcount_out   (hcount_out),
      .vcount_out   (vcount_out),
      .hblnk_out    (hblnk_out),
      .vblnk_out    (vblnk_out),
      .rgb_out      (rgb_out),
      .sel_idx      (sel_idx),
      .choice       (choice),
      .choice_valid (choice_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (choice_valid === 1'b1) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drive one pixel, queue its expected result, compare one cycle later
   task automatic drive_pix(input string tag, input int h, input int v,
                            input logic hb, input logic vb, input logic [11:0] exp);
      hcount_in = 11'(h);
      vcount_in = 10'(v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      exp_rgb_q.push_back(exp);
      exp_h_q.push_back(11'(h));
      exp_v_q.push_back(10'(v));
      @(posedge clk); #1;
      chk({tag, "_rgb"}, rgb_out, exp_rgb_q.pop_front());
      chk({tag, "_hcnt"}, hcount_out, exp_h_q.pop_front());
      chk({tag, "_vcnt"}, vcount_out, exp_v_q.pop_front());
      hblnk_in = 1'b0;
      vblnk_in = 1'b0;
   endtask

   task automatic frame_tick();
      vblnk_in = 1'b1;
      @(posedge clk); #1;
      vblnk_in = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic press(input logic u, input logic d, input logic e);
      key_up = u; key_down = d; key_enter = e;
      @(posedge clk); #1;
      key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      hcount_in = '0; vcount_in = '0; hblnk_in = 1'b0; vblnk_in = 1'b0;
      menu_enable = 1'b0; key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rgb", rgb_out, 0);
      chk("rst_sel", sel_idx, 0);
      chk("rst_choice", choice, 0);
      chk("rst_valid", choice_valid, 0);
      chk("rst_hcnt", hcount_out, 0);
      chk("rst_vcnt", vcount_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // IDLE renders black, then enabling enters NAV with highlight on
      drive_pix("idle", 530, 335, 0, 0, 12'h000);
      menu_enable = 1'b1;
      drive_pix("idle_en", 530, 335, 0, 0, 12'h000);
      chk("nav_sel0", sel_idx, 0);
      drive_pix("nav_hl_on", 530, 335, 0, 0, C_SEL);

      repeat (15) frame_tick();
      drive_pix("blink15", 530, 335, 0, 0, C_SEL);
      frame_tick();
      drive_pix("blink16", 530, 335, 0, 0, C_BTN);
      repeat (16) frame_tick();
      drive_pix("blink32", 530, 335, 0, 0, C_SEL);

      drive_pix("brd_left", 1, 100, 0, 0, C_BRD);
      drive_pix("brd_right", 1022, 400, 0, 0, C_BRD);
      drive_pix("brd_bot", 300, 766, 0, 0, C_BRD);
      drive_pix("brd_top", 300, 2, 0, 0, C_BRD);
      drive_pix("brd_in_l", 3, 100, 0, 0, C_BG);
      drive_pix("brd_in_r", 1020, 400, 0, 0, C_BG);
      drive_pix("brd_edge_r", 1021, 400, 0, 0, C_BRD);
      drive_pix("gap", 530, 360, 0, 0, C_BG);
      drive_pix("hblank", 530, 335, 1, 0, 12'h000);
      drive_pix("btn0_tl", 500, 320, 0, 0, C_SEL);
      drive_pix("btn0_br", 560, 350, 0, 0, C_SEL);
      drive_pix("btn0_xout", 561, 320, 0, 0, C_BG);
      drive_pix("btn0_yout", 530, 351, 0, 0, C_BG);
      drive_pix("btn0_xpre", 499, 335, 0, 0, C_BG);

      press(0, 1, 0); chk("dn1", sel_idx, 1);
      drive_pix("b1_sel", 530, 386, 0, 0, C_SEL);
      drive_pix("b0_unsel", 530, 335, 0, 0, C_BTN);
      press(0, 1, 0); chk("dn2", sel_idx, 2);
      drive_pix("b1_unsel", 530, 386, 0, 0, C_BTN);
      press(0, 1, 0); chk("dn3", sel_idx, 3);
      press(0, 1, 0); chk("dn_wrap", sel_idx, 0);
      press(1, 0, 0); chk("up_wrap", sel_idx, 3);
      press(1, 1, 0); chk("up_dn", sel_idx, 3);
      press(1, 0, 0); chk("up2", sel_idx, 2);

      press(0, 1, 1);
      chk("enter_sel", sel_idx, 2);
      drive_pix("conf_b2", 530, 430, 0, 0, C_SEL);
      repeat (29) frame_tick();
      chk("conf29_valid", choice_valid, 0);
      chk("conf29_pulses", pulses, 0);
      vblnk_in = 1'b1;
      @(posedge clk); #1;
      chk("conf30_valid", choice_valid, 1);
      chk("conf30_choice", choice, 2);
      vblnk_in = 1'b0;
      @(posedge clk); #1;
      chk("conf30_pulse_end", choice_valid, 0);
      chk("conf_pulses", pulses, 1);
      drive_pix("done_b0", 530, 335, 0, 0, C_BTN);
      drive_pix("done_b1", 530, 386, 0, 0, C_BTN);
      drive_pix("done_b2", 530, 430, 0, 0, C_BTN);
      drive_pix("done_b3", 530, 480, 0, 0, C_BTN);
      drive_pix("done_vblank", 530, 480, 0, 1, 12'h000);
      press(1, 0, 1);
      chk("done_keys", sel_idx, 2);
      chk("done_hold", choice, 2);

      menu_enable = 1'b0;
      @(posedge clk); #1;
      drive_pix("off_idle", 530, 335, 0, 0, 12'h000);
      chk("off_choice", choice, 2);
      menu_enable = 1'b1;
      @(posedge clk); #1;
      chk("reen_sel", sel_idx, 0);
      press(0, 1, 0);
      press(0, 0, 1);
      repeat (5) frame_tick();
      menu_enable = 1'b0;
      @(posedge clk); #1;
      drive_pix("abort_idle", 530, 386, 0, 0, 12'h000);
      repeat (30) frame_tick();
      chk("abort_pulses", pulses, 1);
      chk("abort_choice", choice, 2);
      menu_enable = 1'b1;
      @(posedge clk); #1;
      chk("abort_reen_sel", sel_idx, 0);

      press(0, 1, 0);
      drive_pix("pre_rst", 700, 200, 0, 0, C_BG);
      rst_n = 1'b0;
      #2;
      chk("arst_rgb", rgb_out, 0);
      chk("arst_hcnt", hcount_out, 0);
      chk("arst_vcnt", vcount_out, 0);
      chk("arst_sel", sel_idx, 0);
      chk("arst_choice", choice, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive_pix("rel0", 10, 20, 0, 0, 12'h000);
      drive_pix("rel1", 11, 21, 0, 0, C_BG);
      drive_pix("rel2", 1, 21, 0, 0, C_BRD);
      chk("rel_pulses", pulses, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
